// File: rtl/led_row_scanner_pkg.sv
// Shared types and constants for the LED matrix scan path: state encoding,
// matrix geometry and the column byte type plus a lowest-set-bit helper.
package led_pkg;

  localparam int LED_ROWS       = 8;
  localparam int LED_COLS       = 8;
  localparam int LED_ROW_STRIDE = 8;

  typedef logic [LED_COLS-1:0] col_byte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_BLANK = 3'd4
  } led_state_e;

  function automatic logic [2:0] lowest_set(input col_byte_t c);
    logic [2:0] idx;
    idx = '0;
    for (int i = LED_COLS - 1; i >= 0; i--) begin
      if (c[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_row_scanner_if.sv
// Frame-buffer read port plus LED matrix drive signals; the scanner is the
// master, the memory/pin side is the slave.
interface led_row_scanner_if #(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 6
);
  import led_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  col_byte_t         rd_data;
  logic              rd_valid;
  logic [ROWS-1:0]   row_sel;
  col_byte_t         col_data;
  logic [2:0]        col_index;
  logic              col_single;
  logic              frame_done;

  modport master (
    output rd_en, rd_addr, row_sel, col_data, col_index, col_single, frame_done,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, row_sel, col_data, col_index, col_single, frame_done,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/led_row_scanner_decoder.sv
// Combinational column decoder: lowest set bit index (0 for an empty byte)
// and a flag that is high only when exactly one bit is set.
module onehot_col_decoder
  import led_pkg::*;
(
  input  col_byte_t  col_i,
  output logic [2:0] index_o,
  output logic       single_o
);

  assign index_o  = lowest_set(col_i);
  assign single_o = (col_i != '0) && ((col_i & (col_i - col_byte_t'(1))) == '0);

endmodule

// File: rtl/led_row_scanner.sv
// Row scanner: reads one column byte per row, shows it for DWELL_CYCLES, walks rows.
// Optional LED_SCAN_BLANK_EN inserts BLANK_CYCLES dark cycles after every row.
module led_row_scanner #(
  parameter int ROWS         = 8,
  parameter int ROW_STRIDE   = 8,
  parameter int ADDR_W       = 6,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  input logic              enable,
  led_row_scanner_if.master bus
);
  import led_pkg::*;

  localparam int PTR_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [PTR_W-1:0] ROW_LAST   = PTR_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  localparam logic [2:0] S_IDLE = 3'(ST_IDLE);
  localparam logic [2:0] S_REQ  = 3'(ST_REQ);
  localparam logic [2:0] S_WAIT = 3'(ST_WAIT);
  localparam logic [2:0] S_SHOW = 3'(ST_SHOW);
`ifdef LED_SCAN_BLANK_EN
  localparam logic [2:0] S_BLANK    = 3'(ST_BLANK);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] row_ptr_q, row_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  col_byte_t        col_q, col_d;
  logic [2:0]       idx_q, idx_d;
  logic             single_q, single_d;
  logic             frame_done_q, frame_done_d;

  logic [2:0]       dec_idx;
  logic             dec_single;
  logic             show;

  // Decode the incoming byte so the index/flag register alongside col_q.
  onehot_col_decoder u_dec (
    .col_i    (bus.rd_data),
    .index_o  (dec_idx),
    .single_o (dec_single)
  );

  always_comb begin
    state_d      = state_q;
    row_ptr_d    = row_ptr_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    idx_d        = idx_q;
    single_d     = single_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rd_valid) begin
          col_d    = bus.rd_data;
          idx_d    = dec_idx;
          single_d = dec_single;
          cnt_d    = '0;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d        = '0;
          row_ptr_d    = (row_ptr_q == ROW_LAST) ? '0 : row_ptr_q + PTR_W'(1);
          frame_done_d = (row_ptr_q == ROW_LAST);
`ifdef LED_SCAN_BLANK_EN
          state_d      = S_BLANK;
`else
          state_d      = enable ? S_REQ : S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef LED_SCAN_BLANK_EN
      S_BLANK: begin
        // enable is judged after the dark gap so a late drop still parks cleanly.
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = enable ? S_REQ : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      row_ptr_q    <= '0;
      cnt_q        <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      single_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_ptr_q    <= row_ptr_d;
      cnt_q        <= cnt_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      single_q     <= single_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Everything visible on the pins is dark outside SHOW.
  assign show           = (state_q == S_SHOW);
  assign bus.rd_en      = (state_q == S_REQ);
  assign bus.rd_addr    = bus.rd_en ? ADDR_W'(32'(row_ptr_q) * ROW_STRIDE) : '0;
  assign bus.row_sel    = show ? (ROWS'(1) << row_ptr_q) : '0;
  assign bus.col_data   = show ? col_q : '0;
  assign bus.col_index  = show ? idx_q : '0;
  assign bus.col_single = show & single_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/led_row_scanner.md
Name: led_row_scanner

Overview:
- Reader side of the LED frame buffer. The random data/address selectors write one-hot column bytes at row addresses 0, 8, …, 56; this block reads them back.
- Walks rows 0..ROWS-1, issues one read per row and drives one-hot row select plus column data for a fixed dwell time.
- Decodes the column byte back into a 3-bit index for the catch/score logic.
- Sits between the frame-buffer memory and the LED matrix pins.

Parameters:
- ROWS, 8, number of matrix rows scanned per frame (2..8)
- ROW_STRIDE, 8, address step between consecutive rows
- ADDR_W, 6, read address width
- DWELL_CYCLES, 1000, clock cycles each row is held visible (≥1)
- BLANK_CYCLES, 4, dark cycles between rows (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scanning allowed; sampled each cycle
- rd_en  out  1  one-cycle read strobe to frame buffer
- rd_addr  out  ADDR_W  read address = row_ptr*ROW_STRIDE
- rd_data  in  8  column byte returned by frame buffer
- rd_valid  in  1  rd_data valid this cycle
- row_sel  out  ROWS  one-hot active row, all-zero when dark
- col_data  out  8  column pattern for the active row
- col_index  out  3  position of lowest set bit of col_data
- col_single  out  1  col_data has exactly one bit set
- frame_done  out  1  one-cycle pulse after last row's dwell ends

Behaviour:
- Interface: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; row_ptr 0; dwell counter 0.
- FSM states: IDLE, REQ, WAIT, SHOW, plus BLANK (optional feature only).
- IDLE: row_sel = 0, col_data = 0. Moves to REQ on the cycle after enable=1 is sampled.
- REQ: rd_en = 1 for exactly one cycle, rd_addr = row_ptr*ROW_STRIDE (truncated to ADDR_W). Next state WAIT.
- WAIT: holds until rd_valid=1, then registers rd_data into col_data and moves to SHOW.
  - No timeout.
  - rd_valid in any other state is ignored.
  - rd_valid in the same cycle as rd_en is ignored.
- SHOW: row_sel = 1<<row_ptr; col_data stable for exactly DWELL_CYCLES cycles.
- End of dwell:
  - row_ptr increments; at ROWS-1 it wraps to 0 and frame_done pulses in the following cycle.
  - Then REQ (or BLANK with the feature).
- Latency: with a 1-cycle memory, enable sampled at cycle 0 → rd_en at cycle 1 → rd_valid at cycle 2 → row visible at cycle 3.
- Decode (registered, updated with col_data):
  - col_index = lowest set bit of col_data; 0 if col_data = 0.
  - col_single = 1 only for a single set bit. 0x00 and multi-bit (e.g. 0x05) give 0.
- enable dropped mid-row: current SHOW dwell completes, row_ptr advances, then IDLE with row_sel/col_data cleared. row_ptr is retained; the next enable resumes at that row.
- enable dropped in REQ/WAIT: read still completes and the row is shown for its dwell, then IDLE.
- Reset mid-operation: reset wins on the same edge; everything returns to reset values, and any in-flight rd_valid is ignored.
- rd_data changing during SHOW has no effect; only the WAIT capture matters.

Optional Feature:
- Macro: LED_SCAN_BLANK_EN.
- Defined: after each SHOW dwell the FSM enters BLANK for BLANK_CYCLES cycles, with row_sel = 0 and col_data = 0 (ghosting suppression). frame_done timing is unchanged relative to the end of dwell.
- Undefined: no BLANK state; SHOW goes directly to REQ, and BLANK_CYCLES is unused.

Decomposition:
- Shared package `led_pkg`:
  - state enum (IDLE, REQ, WAIT, SHOW, BLANK)
  - LED_ROWS=8, LED_COLS=8, ROW_STRIDE=8
  - column byte typedef
- Sub-module `onehot_col_decoder`: combinational 8→3 lowest-bit encoder plus single-bit flag; the scanner registers its outputs.

Test Plan:
- Reset, then enable=1 with a 1-cycle memory returning 0x01,0x02,…,0x80 for rows 0..7 → rd_addr sequence 0,8,…,56. Row r shows row_sel=1<<r, col_data=1<<r, col_index=r, col_single=1. frame_done pulses once after row 7.
- DWELL_CYCLES=5 → row_sel for each row is stable exactly 5 cycles; first row visible 3 cycles after enable is sampled.
- Memory returns 0x05 then 0x00 → col_single=0 both times; col_index=0 for both.
- Deassert enable during row 3 SHOW → row 3 completes its dwell, then row_sel=0. Re-enable → rd_addr=32 (row 4). frame_done does not pulse until row 7 completes.
- Assert reset in WAIT with rd_valid arriving the same cycle → all outputs 0 next cycle; col_data is not updated.
- With LED_SCAN_BLANK_EN and BLANK_CYCLES=4 → 4 cycles of row_sel=0 between every pair of rows, including the row 7→0 wrap. Without the macro → back-to-back REQ after dwell.
